// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit Custom CPU control path.
//   - Opcode constants (numeric values of the instruction word).
//   - ALU operation encodings driven on alu_op.
//   - Sequencer state enum.
// No ports; imported by ir_decode and ir_sequencer.
package cpu_pkg;

  // Opcodes are held as 32-bit unsigned constants.  The decoder widens the
  // instruction word to match, which keeps them usable for any OPW.
  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_AND = 4;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JZ  = 7;
  localparam int unsigned OP_HLT = 15;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/ir_decode.sv
// Purely combinational opcode decoder.
// Ports:
//   op          in   OPW  instruction word (IR output)
//   zero_flag   in   1    accumulator-zero flag, qualifies JZ
//   alu_op      out  2    ALU operation (00 pass, 01 add, 10 sub, 11 and)
//   acc_we      out  1    accumulator write request
//   pc_load_req out  1    PC load request (JMP, or JZ with zero_flag)
//   is_halt     out  1    opcode is HLT
//   illegal     out  1    opcode not in the instruction set
module ir_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] op,
  input  logic           zero_flag,
  output logic [1:0]     alu_op,
  output logic           acc_we,
  output logic           pc_load_req,
  output logic           is_halt,
  output logic           illegal
);

  logic [31:0] op_w;

  always_comb begin
    op_w        = 32'(op);
    alu_op      = ALU_PASS;
    acc_we      = 1'b0;
    pc_load_req = 1'b0;
    is_halt     = 1'b0;
    illegal     = 1'b0;
    case (op_w)
      OP_NOP: ;
      OP_LDA: begin alu_op = ALU_PASS; acc_we = 1'b1; end
      OP_ADD: begin alu_op = ALU_ADD;  acc_we = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB;  acc_we = 1'b1; end
      OP_AND: begin alu_op = ALU_AND;  acc_we = 1'b1; end
      OP_JMP: pc_load_req = 1'b1;
      OP_JZ:  pc_load_req = zero_flag;
      OP_HLT: is_halt = 1'b1;
      // Unknown opcodes behave as NOP but are flagged.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ir_sequencer.sv
// Fetch/decode/execute controller for the 4-bit Custom CPU.
// Requests an instruction from program memory, pulses the IR load enable to
// capture it, then decodes the IR output into PC/ALU/accumulator controls.
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous reset, active low
//   start      in   1    leave IDLE/HALT and start fetching
//   mem_ready  in   1    program memory data valid (used in FETCH only)
//   instr      in   OPW  IR output
//   zero_flag  in   1    accumulator-zero flag
//   mem_rd     out  1    program memory read request
//   ir_re      out  1    IR load enable
//   pc_inc     out  1    PC increment
//   pc_load    out  1    PC load from jump target
//   alu_op     out  2    ALU operation
//   acc_we     out  1    accumulator write enable
//   halted     out  1    sequencer is in HALT
//   fault      out  1    sticky fetch-timeout / illegal-opcode flag
// Handshake: memory is a request/valid pair.  mem_rd stays high for every
// FETCH cycle; the first cycle with mem_ready high completes the request and
// the data is captured into the IR on the following (LOAD) cycle.
// Every output is a register written together with the next state, so no
// input reaches an output combinationally.
module ir_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mem_ready,
  input  logic [OPW-1:0] instr,
  input  logic           zero_flag,
  output logic           mem_rd,
  output logic           ir_re,
  output logic           pc_inc,
  output logic           pc_load,
  output logic [1:0]     alu_op,
  output logic           acc_we,
  output logic           halted,
  output logic           fault
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter holds the number of FETCH cycles already spent without
  // mem_ready; the cycle where it equals TIMEOUT-1 is the last one allowed.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;

  logic [1:0] d_alu_op;
  logic       d_acc_we;
  logic       d_pc_load;
  logic       d_is_halt;
  logic       d_illegal;

  ir_decode #(.OPW(OPW)) u_decode (
    .op          (instr),
    .zero_flag   (zero_flag),
    .alu_op      (d_alu_op),
    .acc_we      (d_acc_we),
    .pc_load_req (d_pc_load),
    .is_halt     (d_is_halt),
    .illegal     (d_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_rd  <= 1'b0;
      ir_re   <= 1'b0;
      pc_inc  <= 1'b0;
      pc_load <= 1'b0;
      alu_op  <= ALU_PASS;
      acc_we  <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      // Single-cycle strobes drop unless the next state re-asserts them.
      ir_re   <= 1'b0;
      pc_inc  <= 1'b0;
      pc_load <= 1'b0;
      alu_op  <= ALU_PASS;
      acc_we  <= 1'b0;

      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            cnt    <= '0;
            mem_rd <= 1'b1;
            halted <= 1'b0;
            fault  <= 1'b0;
          end
        end

        S_FETCH: begin
          // mem_ready takes priority over a timeout in the same cycle.
          if (mem_ready) begin
            state  <= S_LOAD;
            cnt    <= '0;
            mem_rd <= 1'b0;
            ir_re  <= 1'b1;
            pc_inc <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state  <= S_HALT;
            cnt    <= '0;
            mem_rd <= 1'b0;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LOAD: state <= S_DECODE;

        S_DECODE: begin
          // The IR was loaded at the end of LOAD, so instr is stable here.
          if (d_is_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state   <= S_EXEC;
            alu_op  <= d_alu_op;
            acc_we  <= d_acc_we;
            pc_load <= d_pc_load;
            if (d_illegal) fault <= 1'b1;
          end
        end

        S_EXEC: begin
          state  <= S_FETCH;
          cnt    <= '0;
          mem_rd <= 1'b1;
        end

        default: begin
          state  <= S_IDLE;
          mem_rd <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_sequencer.sv
module tb_ir_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mem_ready;
  logic [3:0] instr;
  logic       zero_flag;
  logic       mem_rd;
  logic       ir_re;
  logic       pc_inc;
  logic       pc_load;
  logic [1:0] alu_op;
  logic       acc_we;
  logic       halted;
  logic       fault;

  int total = 0;
  int bad   = 0;

  ir_sequencer #(.OPW(4), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_ready (mem_ready),
    .instr     (instr),
    .zero_flag (zero_flag),
    .mem_rd    (mem_rd),
    .ir_re     (ir_re),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .alu_op    (alu_op),
    .acc_we    (acc_we),
    .halted    (halted),
    .fault     (fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // inputs for the next edge are driven from that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting in a FETCH cycle: complete the fetch, present op in the IR,
  // and check LOAD, EXEC and the return to FETCH.
  task automatic run_op(input string tag, input logic [3:0] op, input logic zf,
                        input logic [1:0] e_alu, input logic e_acc,
                        input logic e_pcl, input logic e_fault);
    mem_ready = 1'b1;
    step();                                   // LOAD
    chk({tag, ".ir_re"},  ir_re,  1'b1);
    chk({tag, ".pc_inc"}, pc_inc, 1'b1);
    mem_ready = 1'b0;
    instr     = op;
    zero_flag = zf;
    step();                                   // DECODE
    chk({tag, ".dec_quiet"}, {ir_re, pc_inc, pc_load, acc_we, mem_rd}, 5'b0);
    step();                                   // EXEC
    chk({tag, ".alu_op"},  alu_op,  e_alu);
    chk({tag, ".acc_we"},  acc_we,  e_acc);
    chk({tag, ".pc_load"}, pc_load, e_pcl);
    chk({tag, ".pc_inc"},  pc_inc,  1'b0);
    chk({tag, ".fault"},   fault,   e_fault);
    step();                                   // FETCH again
    chk({tag, ".refetch"}, mem_rd, 1'b1);
    chk({tag, ".strobes_off"}, {acc_we, pc_load}, 2'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; instr = 4'd0; zero_flag = 1'b0;
    step();
    step();
    chk("reset_outs", {mem_rd, ir_re, pc_inc, pc_load, alu_op, acc_we, halted, fault}, 9'b0);
    rst_n = 1'b1;
    mem_ready = 1'b1;                         // ignored in IDLE
    step();
    chk("idle_ignores_ready", {mem_rd, ir_re}, 2'b0);
    mem_ready = 1'b0;

    // Basic fetch: ADD with mem_ready on the 2nd FETCH cycle
    start = 1'b1;
    step();                                   // FETCH 1
    chk("start_mem_rd", mem_rd, 1'b1);
    start = 1'b0;
    step();                                   // FETCH 2
    chk("fetch2_wait", {mem_rd, ir_re}, 2'b10);
    run_op("add", 4'd2, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);

    // ALU opcodes, NOP and jumps
    run_op("lda",  4'd1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    run_op("sub",  4'd3, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    run_op("and",  4'd4, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    run_op("nop",  4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run_op("jz1",  4'd7, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    run_op("jz0",  4'd7, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    run_op("jmp0", 4'd6, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    run_op("jmp1", 4'd6, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);

    // start is ignored while running
    start = 1'b1;
    run_op("illegal", 4'd9, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    run_op("sticky", 4'd2, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);

    // Halt and restart
    mem_ready = 1'b1;
    step();                                   // LOAD
    mem_ready = 1'b0;
    instr = 4'd15;
    step();                                   // DECODE
    step();                                   // HALT
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_quiet", {mem_rd, ir_re, pc_inc, pc_load, acc_we}, 5'b0);
    chk("hlt_fault_kept", fault, 1'b1);
    mem_ready = 1'b1;                         // ignored in HALT
    step();
    chk("hlt_stays", {halted, mem_rd}, 2'b10);
    mem_ready = 1'b0;
    start = 1'b1;
    step();                                   // FETCH 1
    start = 1'b0;
    chk("restart", {mem_rd, halted, fault}, 3'b100);

    // Timeout: 15 FETCH cycles without mem_ready
    for (int i = 2; i <= 15; i++) step();     // FETCH 15
    chk("to_cycle15", {mem_rd, halted, fault}, 3'b100);
    step();
    chk("to_halt", {mem_rd, halted, fault}, 3'b011);

    // Timeout boundary: mem_ready on the 15th cycle wins
    start = 1'b1;
    step();                                   // FETCH 1
    start = 1'b0;
    chk("to2_restart", fault, 1'b0);
    for (int i = 2; i <= 15; i++) step();     // FETCH 15
    chk("to2_cycle15", mem_rd, 1'b1);
    run_op("to2_load", 4'd1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("to2_no_halt", halted, 1'b0);

    // Reset mid-FETCH (mem_rd high)
    step();
    chk("pre_rst_fetch", mem_rd, 1'b1);
    rst_n = 1'b0;
    step();
    step();
    chk("mid_rst", {mem_rd, ir_re, pc_inc, pc_load, acc_we, halted, fault}, 7'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {mem_rd, halted}, 2'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
